// File: rtl/simon_pkg.sv
// Shared constants, helpers and state encoding for the SIMON64/128 key schedule.
// Words are 32 bits; rotations treat bit 31 as the MSB.
package simon_pkg;

  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 4;
  localparam int ROUNDS    = 44;

  localparam logic [WORD_W-1:0] C_CONST = 32'hFFFFFFFC;
  localparam logic [63:0]       Z3      = 64'hFC2CE51207A635DB;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [WORD_W-1:0] ror1(input logic [WORD_W-1:0] x);
    return {x[0], x[WORD_W-1:1]};
  endfunction

  function automatic logic [WORD_W-1:0] ror3(input logic [WORD_W-1:0] x);
    return {x[2:0], x[WORD_W-1:3]};
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One SIMON64/128 key-schedule step: derives k(i+4) from k(i), k(i+1), k(i+3)
// and the z bit for that step.
module simon_key_step
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w3,
  input  logic              z_bit,
  output logic [WORD_W-1:0] knew
);

  logic [WORD_W-1:0] a;

  // The z bit only ever touches the LSB.
  always_comb begin
    a    = ror3(w3) ^ w1;
    knew = w0 ^ a ^ ror1(a) ^ C_CONST ^ {{(WORD_W-1){1'b0}}, z_bit};
  end

endmodule

// File: rtl/simon_key_expander.sv
// Streams SIMON64/128 round keys k0..k43 from a 128-bit master key over valid/ready.
// The window always holds k(i)..k(i+3), so the presented round key is simply w0.
module simon_key_expander #(
  parameter int          ROUNDS    = simon_pkg::ROUNDS,
  parameter int          KEY_WORDS = simon_pkg::KEY_WORDS,
  parameter logic [63:0] Z_SEQ     = simon_pkg::Z3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  key_valid,
  output logic                                  key_ready,
  input  logic [KEY_WORDS*simon_pkg::WORD_W-1:0] key,
  output logic                                  rk_valid,
  input  logic                                  rk_ready,
  output logic [simon_pkg::WORD_W-1:0]           rk_data,
  output logic [5:0]                            rk_index,
  output logic                                  rk_last,
  output logic                                  busy
);

  import simon_pkg::*;

  localparam logic       ST_IDLE  = logic'(IDLE);
  localparam logic       ST_EMIT  = logic'(EMIT);
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  logic              state;
  logic [5:0]        idx;
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] knew;

  // While k(i) is presented, the step computes k(i+4), whose z index is i.
  simon_key_step u_step (
    .w0    (w0),
    .w1    (w1),
    .w3    (w3),
    .z_bit (Z_SEQ[idx]),
    .knew  (knew)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            w0    <= key[0*WORD_W +: WORD_W];
            w1    <= key[1*WORD_W +: WORD_W];
            w2    <= key[2*WORD_W +: WORD_W];
            w3    <= key[3*WORD_W +: WORD_W];
            idx   <= '0;
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_IDLE;
            end else begin
              w0  <= w1;
              w1  <= w2;
              w2  <= w3;
              w3  <= knew;
              idx <= idx + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All handshake outputs come straight from registers; rk_ready never feeds rk_valid.
  assign key_ready = (state == ST_IDLE);
  assign rk_valid  = (state == ST_EMIT);
  assign busy      = (state != ST_IDLE);
  assign rk_data   = w0;
  assign rk_index  = idx;
  assign rk_last   = (idx == LAST_IDX);

endmodule

// File: tb/tb_simon_key_expander.sv
// Directed bench for simon_key_expander: standard vector, backpressure, reset,
// ignored and back-to-back key loads, and idle behaviour.
module tb_simon_key_expander;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_data;
  logic [5:0]   rk_index;
  logic         rk_last;
  logic         busy;

  int pass_count = 0;
  int check_count = 0;

  localparam logic [127:0] K1 = 128'h1B1A1918_13121110_0B0A0908_03020100;
  localparam logic [127:0] K2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] K3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic [31:0] head [5] = '{32'h03020100, 32'h0B0A0908, 32'h13121110, 32'h1B1A1918, 32'h70A011C3};

  simon_key_expander dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference key schedule written in the textbook form (~k ^ 3 instead of ^ c).
  function automatic logic [31:0] model_key(input logic [127:0] k, input int n);
    logic [31:0] kk [0:43];
    logic [31:0] tmp;
    logic [63:0] z;
    z = 64'hFC2CE51207A635DB;
    for (int i = 0; i < 4; i++) kk[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp   = {kk[i-1][2:0], kk[i-1][31:3]};
      tmp   = tmp ^ kk[i-3];
      tmp   = tmp ^ {tmp[0], tmp[31:1]};
      kk[i] = ~kk[i-4] ^ tmp ^ {31'b0, z[i-4]} ^ 32'd3;
    end
    return kk[n];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    key       = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] k);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_count++;
    if (key_ready !== 1'b1) $display("[TB] FAIL reset_key_ready got=%b exp=1", key_ready); else pass_count++;
    check_count++;
    if (rk_valid !== 1'b0) $display("[TB] FAIL reset_rk_valid got=%b exp=0", rk_valid); else pass_count++;
    check_count++;
    if (rk_index !== 6'd0) $display("[TB] FAIL reset_rk_index got=%0d exp=0", rk_index); else pass_count++;
    check_count++;
    if (rk_data !== 32'd0) $display("[TB] FAIL reset_rk_data got=%h exp=0", rk_data); else pass_count++;
    check_count++;
    if (rk_last !== 1'b0) $display("[TB] FAIL reset_rk_last got=%b exp=0", rk_last); else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else pass_count++;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 100; c++) begin
      check_count++;
      if ({rk_valid, key_ready, busy, rk_last, rk_index, rk_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0})
        $display("[TB] FAIL idle_outputs cycle=%0d got v=%b kr=%b b=%b l=%b i=%0d d=%h exp v=0 kr=1 b=0 l=0 i=0 d=0",
                 c, rk_valid, key_ready, busy, rk_last, rk_index, rk_data);
      else pass_count++;
      @(negedge clk);
    end
  endtask

  task automatic test_standard_vector();
    rk_ready = 1'b1;
    send_key(K1);
    for (int j = 0; j < 44; j++) begin
      check_count++;
      if (rk_valid !== 1'b1 || rk_index !== 6'(j))
        $display("[TB] FAIL std_index got v=%b i=%0d exp v=1 i=%0d", rk_valid, rk_index, j);
      else pass_count++;
      check_count++;
      if (rk_data !== model_key(K1, j))
        $display("[TB] FAIL std_data i=%0d got=%h exp=%h", j, rk_data, model_key(K1, j));
      else pass_count++;
      if (j < 5) begin
        check_count++;
        if (rk_data !== head[j]) $display("[TB] FAIL std_head i=%0d got=%h exp=%h", j, rk_data, head[j]);
        else pass_count++;
      end
      check_count++;
      if (rk_last !== (j == 43)) $display("[TB] FAIL std_last i=%0d got=%b exp=%b", j, rk_last, (j == 43));
      else pass_count++;
      @(negedge clk);
    end
    check_count++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL std_done got kr=%b v=%b b=%b exp kr=1 v=0 b=0", key_ready, rk_valid, busy);
    else pass_count++;
  endtask

  task automatic test_backpressure();
    int          j;
    int          cycles;
    logic        stalled;
    logic [31:0] prev_data;
    j = 0;
    cycles = 0;
    stalled = 1'b0;
    prev_data = '0;
    rk_ready = 1'b0;
    send_key(K1);
    while (j < 44 && cycles < 1000) begin
      check_count++;
      if (rk_valid !== 1'b1 || rk_index !== 6'(j) || rk_data !== model_key(K1, j))
        $display("[TB] FAIL bp_beat got v=%b i=%0d d=%h exp v=1 i=%0d d=%h",
                 rk_valid, rk_index, rk_data, j, model_key(K1, j));
      else pass_count++;
      if (stalled) begin
        check_count++;
        if (rk_data !== prev_data) $display("[TB] FAIL bp_stable got=%h exp=%h", rk_data, prev_data);
        else pass_count++;
      end
      rk_ready  = 1'($urandom_range(0, 1));
      stalled   = ~rk_ready;
      prev_data = rk_data;
      if (rk_ready) j++;
      @(negedge clk);
      cycles++;
    end
    rk_ready = 1'b1;
    check_count++;
    if (j != 44 || rk_valid !== 1'b0 || key_ready !== 1'b1)
      $display("[TB] FAIL bp_done got beats=%0d v=%b kr=%b exp beats=44 v=0 kr=1", j, rk_valid, key_ready);
    else pass_count++;
  endtask

  task automatic test_reset_midstream();
    rk_ready = 1'b1;
    send_key(K1);
    for (int j = 0; j < 18; j++) @(negedge clk);
    check_count++;
    if (rk_index !== 6'd18 || rk_data !== model_key(K1, 18))
      $display("[TB] FAIL mid_before got i=%0d d=%h exp i=18 d=%h", rk_index, rk_data, model_key(K1, 18));
    else pass_count++;
    rst = 1'b1;
    @(negedge clk);
    check_count++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_index !== 6'd0)
      $display("[TB] FAIL mid_reset got v=%b kr=%b b=%b i=%0d exp v=0 kr=1 b=0 i=0",
               rk_valid, key_ready, busy, rk_index);
    else pass_count++;
    rst = 1'b0;
    send_key(K2);
    for (int j = 0; j < 44; j++) begin
      check_count++;
      if (rk_valid !== 1'b1 || rk_index !== 6'(j) || rk_data !== model_key(K2, j))
        $display("[TB] FAIL mid_fresh got v=%b i=%0d d=%h exp v=1 i=%0d d=%h",
                 rk_valid, rk_index, rk_data, j, model_key(K2, j));
      else pass_count++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_key();
    rk_ready = 1'b1;
    send_key(K1);
    for (int j = 0; j < 44; j++) begin
      if (j == 5) begin
        key       = K2;
        key_valid = 1'b1;
      end
      if (j == 30) key_valid = 1'b0;
      check_count++;
      if (key_ready !== 1'b0 || rk_index !== 6'(j) || rk_data !== model_key(K1, j))
        $display("[TB] FAIL ign_stream got kr=%b i=%0d d=%h exp kr=0 i=%0d d=%h",
                 key_ready, rk_index, rk_data, j, model_key(K1, j));
      else pass_count++;
      @(negedge clk);
    end
    @(negedge clk);
    check_count++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1)
      $display("[TB] FAIL ign_no_load got v=%b kr=%b exp v=0 kr=1", rk_valid, key_ready);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    @(negedge clk);
    key       = K1;
    key_valid = 1'b1;
    @(negedge clk);
    key = K3;
    for (int j = 0; j < 44; j++) begin
      check_count++;
      if (rk_valid !== 1'b1 || rk_index !== 6'(j) || rk_data !== model_key(K1, j))
        $display("[TB] FAIL b2b_first got v=%b i=%0d d=%h exp v=1 i=%0d d=%h",
                 rk_valid, rk_index, rk_data, j, model_key(K1, j));
      else pass_count++;
      @(negedge clk);
    end
    check_count++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1)
      $display("[TB] FAIL b2b_gap got v=%b kr=%b exp v=0 kr=1", rk_valid, key_ready);
    else pass_count++;
    @(negedge clk);
    key_valid = 1'b0;
    for (int j = 0; j < 44; j++) begin
      check_count++;
      if (rk_valid !== 1'b1 || rk_index !== 6'(j) || rk_data !== model_key(K3, j))
        $display("[TB] FAIL b2b_second got v=%b i=%0d d=%h exp v=1 i=%0d d=%h",
                 rk_valid, rk_index, rk_data, j, model_key(K3, j));
      else pass_count++;
      @(negedge clk);
    end
    check_count++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1)
      $display("[TB] FAIL b2b_done got v=%b kr=%b exp v=0 kr=1", rk_valid, key_ready);
    else pass_count++;
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    key       = '0;
    test_reset();
    test_idle();
    test_standard_vector();
    test_backpressure();
    test_reset_midstream();
    test_ignored_key();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/simon_key_expander.md
Name: simon_key_expander

Overview:
- Sequential key-schedule engine for SIMON64/128 (32-bit words, m = 4 key words, T = 44 rounds).
- Accepts a 128-bit master key and streams round keys k0..k43 over a valid/ready interface, one word per accepted beat.
- Sits directly upstream of the round-function datapath.
- Keeps a four-word sliding window and applies the key-schedule step each beat, using the z3 constant sequence and c = 0xFFFFFFFC.

Parameters:
- ROUNDS, 44, number of round keys emitted per key load.
- KEY_WORDS, 4, number of 32-bit master key words (m).
- Z_SEQ, 64'hFC2CE51207A635DB, z3 sequence; bit j (LSB-first) is the z bit for derived key k(j+4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  master key offered.
- key_ready  output  1  expander can accept a key (high only in IDLE).
- key  input  128  master key; key[31:0]=k0, key[63:32]=k1, key[95:64]=k2, key[127:96]=k3.
- rk_valid  output  1  rk_data holds a valid round key.
- rk_ready  input  1  downstream consumes the round key.
- rk_data  output  32  current round key.
- rk_index  output  6  index i of rk_data, 0..43.
- rk_last  output  1  high with rk_index == ROUNDS-1.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, key_ready=1, rk_valid=0, rk_index=0, rk_data=0, rk_last=0, busy=0, window cleared. Reset has priority over every other event, including mid-stream; the partial stream is abandoned and nothing more is emitted.
- States: IDLE, EMIT.
- IDLE -> EMIT: on key_valid && key_ready.
  - Load window w0..w3 = key words k0..k3.
  - Set rk_index=0, rk_data=k0, rk_valid=1.
  - Latency: key handshake to first rk_valid is 1 cycle.
- EMIT:
  - rk_data, rk_index and rk_last hold stable while rk_valid && !rk_ready (AXI-style; no combinational path from rk_ready to rk_valid).
  - On each rk_valid && rk_ready beat with rk_index < ROUNDS-1:
    - Shift the window: w0<=w1, w1<=w2, w2<=w3, w3<=knew.
    - rk_index increments.
    - rk_data presents the next word.
  - Throughput: one key per cycle under continuous rk_ready.
- knew (used for i >= 4), with i = index of the key being produced:
  - A = ror3(w3) ^ w1
  - knew = w0 ^ A ^ ror1(A) ^ 0xFFFFFFFC ^ Z_SEQ[i-4]
  - The z bit enters at the LSB only. Rotations are right rotations on 32-bit words, with bit 31 = MSB.
  - For i = 1..3, the next word comes directly from the window, with no arithmetic.
  - i-4 ranges 0..39, so the z index never wraps.
- rk_last=1 exactly when rk_index == ROUNDS-1.
- On the handshake of the last beat: EMIT -> IDLE, rk_valid=0, key_ready=1. A new key is accepted no earlier than the cycle after that handshake.
- key_valid asserted during EMIT is ignored (key_ready=0); the key is not sampled.
- Optional implementation: the step datapath may be combinational from the window registers, or pre-computed one beat ahead. Both are acceptable if the interface timing above holds.

Decomposition:
- Shared package simon_pkg holds:
  - WORD_W = 32, KEY_WORDS = 4, ROUNDS = 44
  - C_CONST = 32'hFFFFFFFC
  - Z3 = 64'hFC2CE51207A635DB
  - functions ror1 and ror3
  - the state enum typedef
- One natural sub-module: simon_key_step, a purely combinational computation of knew from (w0, w1, w3, z bit). The sequencer instantiates it once.

Test Plan:
- Standard vector: key = 128'h1B1A1918_13121110_0B0A0908_03020100, rk_ready tied high. Required:
  - rk_data over indices 0..4 = 03020100, 0B0A0908, 13121110, 1B1A1918, 70A011C3.
  - All 44 keys match the software golden model.
  - rk_last on index 43 only.
  - key_ready returns high the following cycle.
- Backpressure: same key, rk_ready toggled pseudo-randomly. The key sequence is identical to the previous test, and rk_data/rk_index are stable during every stall cycle.
- Reset mid-stream: assert rst after index 17 is accepted. Next cycle rk_valid=0, key_ready=1, busy=0. A fresh key then streams from index 0 correctly.
- Ignored key: drive key_valid with a different key during EMIT. The stream is unaffected, and the second key is accepted only after rk_last completes.
- Back-to-back loads: key_valid held high with two keys in sequence. The second stream starts exactly 1 cycle after the last beat of the first, and both streams match the model.
- Idle behaviour: no key_valid for 100 cycles after reset. rk_valid stays 0, key_ready stays 1, and outputs stay at their reset values.
